// File: rtl/timer_pkg.sv
// Shared constants for the Avalon multi-channel interval timer.
// Optional feature macro: TIMER_PRESCALER_EN (per-channel clock prescaler).
package timer_pkg;

   localparam int HW_W = 16;

   localparam logic [3:0] REG_STATUS   = 4'd0;
   localparam logic [3:0] REG_CONTROL  = 4'd1;
   localparam logic [3:0] REG_PERIOD0  = 4'd2;
   localparam logic [3:0] REG_SNAP0    = 4'd6;
   localparam logic [3:0] REG_PRESCALE = 4'd10;
   localparam logic [3:0] REG_PENDING  = 4'd11;

   localparam int ST_TO    = 0;
   localparam int ST_RUN   = 1;
   localparam int CT_ITO   = 0;
   localparam int CT_CONT  = 1;
   localparam int CT_START = 2;
   localparam int CT_STOP  = 3;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: down-counter, period, snapshot, TO/RUN.
// TIMER_PRESCALER_EN adds a prescale register and prescale counter.
module timer_channel
   import timer_pkg::*;
#(
   parameter int          CNT_W        = 32,
   parameter int unsigned RESET_PERIOD = 49999
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            wr_i,
   input  logic [3:0]      reg_i,
   input  logic [HW_W-1:0] wdata_i,
   output logic [HW_W-1:0] rdata_o,
   output logic            to_o,
   output logic            irq_o
);
   localparam int NHW = CNT_W / HW_W;
   localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(RESET_PERIOD);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] per_q, per_d;
   logic [CNT_W-1:0] snap_q, snap_d;
   logic [3:0]       ctrl_q, ctrl_d;
   logic             run_q, run_d;
   logic             to_q, to_d;
   logic             nz_q;
   logic             wr_per, wr_snap, tick, evt;

`ifdef TIMER_PRESCALER_EN
   logic [HW_W-1:0] psc_q, psc_d;
   logic [HW_W-1:0] pcnt_q, pcnt_d;
   logic            psc_clr;
   assign tick = (pcnt_q >= psc_q);
`else
   assign tick = 1'b1;
`endif

   assign evt   = (cnt_q == '0) && nz_q;
   assign to_o  = to_q;
   assign irq_o = to_q & ctrl_q[CT_ITO];

   // next state: period/snapshot writes, counting, RUN and TO
   always_comb begin
      per_d  = per_q;
      wr_per = 1'b0;
      for (int k = 0; k < NHW; k++) begin
         if (wr_i && reg_i == REG_PERIOD0 + 4'(k)) begin
            per_d[k*HW_W +: HW_W] = wdata_i;
            wr_per = 1'b1;
         end
      end
      wr_snap = wr_i && reg_i >= REG_SNAP0
                && reg_i < REG_SNAP0 + 4'(NHW);
      snap_d = wr_snap ? cnt_q : snap_q;
      cnt_d  = cnt_q;
      run_d  = run_q;
      ctrl_d = ctrl_q;
      if (run_q && tick) begin
         if (cnt_q == '0) begin
            cnt_d = per_q;
            if (!ctrl_q[CT_CONT]) run_d = 1'b0;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
      if (wr_i && reg_i == REG_CONTROL) begin
         ctrl_d = wdata_i[3:0];
         if (wdata_i[CT_START])     run_d = 1'b1;
         else if (wdata_i[CT_STOP]) run_d = 1'b0;
      end
      if (wr_per) begin
         cnt_d = per_d;
         run_d = 1'b0;
      end
      to_d = to_q;
      if (wr_i && reg_i == REG_STATUS) to_d = 1'b0;
      else if (evt)                    to_d = 1'b1;
   end

`ifdef TIMER_PRESCALER_EN
   // prescaler: one tick every psc_q+1 clks while running
   always_comb begin
      psc_d = psc_q;
      if (wr_i && reg_i == REG_PRESCALE) psc_d = wdata_i;
      psc_clr = wr_per || (run_q && tick && cnt_q == '0)
                || (wr_i && reg_i == REG_CONTROL && wdata_i[CT_START]);
      pcnt_d = pcnt_q;
      if (psc_clr)    pcnt_d = '0;
      else if (run_q) pcnt_d = tick ? '0 : pcnt_q + 1'b1;
   end

   // prescaler state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         psc_q  <= '0;
         pcnt_q <= '0;
      end else begin
         psc_q  <= psc_d;
         pcnt_q <= pcnt_d;
      end
   end
`endif

   // register read mux for this channel
   always_comb begin
      rdata_o = '0;
      case (reg_i)
         REG_STATUS:   rdata_o = {14'b0, run_q, to_q};
         REG_CONTROL:  rdata_o = {12'b0, ctrl_q};
`ifdef TIMER_PRESCALER_EN
         REG_PRESCALE: rdata_o = psc_q;
`endif
         default:      rdata_o = '0;
      endcase
      for (int k = 0; k < NHW; k++) begin
         if (reg_i == REG_PERIOD0 + 4'(k)) rdata_o = per_q[k*HW_W +: HW_W];
         if (reg_i == REG_SNAP0 + 4'(k))   rdata_o = snap_q[k*HW_W +: HW_W];
      end
   end

   // channel state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q  <= RST_CNT;
         per_q  <= RST_CNT;
         snap_q <= '0;
         ctrl_q <= '0;
         run_q  <= 1'b0;
         to_q   <= 1'b0;
         nz_q   <= (RST_CNT != '0);
      end else begin
         cnt_q  <= cnt_d;
         per_q  <= per_d;
         snap_q <= snap_d;
         ctrl_q <= ctrl_d;
         run_q  <= run_d;
         to_q   <= to_d;
         nz_q   <= (cnt_q != '0);
      end
   end

endmodule

// File: rtl/avalon_multi_timer.sv
// Avalon-MM multi-channel interval timer: decode, read mux, irq merge.
// Optional feature macro: TIMER_PRESCALER_EN (per-channel prescaler).
module avalon_multi_timer
   import timer_pkg::*;
#(
   parameter int          NUM_CH       = 4,
   parameter int          CNT_W        = 32,
   parameter int unsigned RESET_PERIOD = 49999
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [3+$clog2(NUM_CH):0] address,
   input  logic                      chipselect,
   input  logic                      write_n,
   input  logic [HW_W-1:0]           writedata,
   output logic [HW_W-1:0]           readdata,
   output logic                      irq
);
   logic [7:0]        ch;
   logic [3:0]        rsel;
   logic              ch_ok, wr;
   logic [HW_W-1:0]   ch_rd [NUM_CH];
   logic [NUM_CH-1:0] ch_to, ch_irq;
   logic [HW_W-1:0]   rd_q, rd_d;

   assign rsel     = address[3:0];
   assign ch       = 8'(address >> 4);
   assign ch_ok    = ch < 8'(NUM_CH);
   assign wr       = chipselect && !write_n && ch_ok;
   assign irq      = |ch_irq;
   assign readdata = rd_q;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      timer_channel #(
         .CNT_W        (CNT_W),
         .RESET_PERIOD (RESET_PERIOD)
      ) u_ch (
         .clk     (clk),
         .reset_n (reset_n),
         .wr_i    (wr && ch == 8'(i)),
         .reg_i   (rsel),
         .wdata_i (writedata),
         .rdata_o (ch_rd[i]),
         .to_o    (ch_to[i]),
         .irq_o   (ch_irq[i])
      );
   end

   // select the addressed channel, or the global pending bitmap
   always_comb begin
      rd_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch == 8'(i)) rd_d = ch_rd[i];
      end
      if (ch_ok && rsel == REG_PENDING) rd_d = HW_W'(ch_to);
   end

   // registered read data, updated every clk
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rd_q <= '0;
      else          rd_q <= rd_d;
   end

endmodule

// File: tb/tb_avalon_multi_timer.sv
// Self-checking bench for avalon_multi_timer.
// Honours TIMER_PRESCALER_EN when it is defined for the build.
module tb_avalon_multi_timer;
   localparam int NUM_CH = 4;
   localparam int CNT_W  = 32;
   localparam int NHW    = CNT_W / 16;
   localparam int AW     = 4 + $clog2(NUM_CH);
   localparam int unsigned RP = 49999;
`ifdef TIMER_PRESCALER_EN
   localparam bit PSC = 1'b1;
`else
   localparam bit PSC = 1'b0;
`endif
   localparam int EXP_I = PSC ? 15 : 3;

   logic          clk, reset_n;
   logic [AW-1:0] address;
   logic          chipselect, write_n;
   logic [15:0]   writedata, readdata;
   logic          irq;

   typedef struct {
      bit          we;
      logic [AW-1:0] a;
      logic [15:0] d;
      logic [15:0] exp;
   } vec_t;

   longint unsigned m_cnt[NUM_CH], m_per[NUM_CH], m_snap[NUM_CH];
   int              m_psc[NUM_CH], m_pc[NUM_CH];
   bit              m_run[NUM_CH], m_to[NUM_CH], m_wasnz[NUM_CH];
   logic [3:0]      m_ctl[NUM_CH];

   int checks = 0, failures = 0, ncyc = 0;

   avalon_multi_timer #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .RESET_PERIOD(RP)
   ) dut (
      .clk(clk), .reset_n(reset_n), .address(address),
      .chipselect(chipselect), .write_n(write_n),
      .writedata(writedata), .readdata(readdata), .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [AW-1:0] ad(input int c, input int r);
      return AW'(c * 16 + r);
   endfunction

   task automatic m_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_cnt[c] = RP; m_per[c] = RP; m_snap[c] = 0;
         m_psc[c] = 0;  m_pc[c] = 0;
         m_run[c] = 0;  m_to[c] = 0;  m_ctl[c] = 4'h0;
         m_wasnz[c] = (RP != 0);
      end
   endtask

   function automatic bit m_irq();
      bit v = 0;
      for (int c = 0; c < NUM_CH; c++) v |= m_to[c] & m_ctl[c][0];
      return v;
   endfunction

   // expected register contents as seen by a read of address a
   function automatic logic [15:0] mread(input logic [AW-1:0] a);
      int c, r;
      logic [15:0] v;
      c = int'(a) / 16; r = int'(a) % 16; v = 16'h0;
      if (c >= NUM_CH) return 16'h0;
      if (r == 0) v = {14'b0, m_run[c], m_to[c]};
      else if (r == 1) v = {12'b0, m_ctl[c]};
      else if (r >= 2 && r < 2 + NHW) v = 16'(m_per[c] >> (16 * (r - 2)));
      else if (r >= 6 && r < 6 + NHW) v = 16'(m_snap[c] >> (16 * (r - 6)));
      else if (r == 10) v = PSC ? 16'(m_psc[c]) : 16'h0;
      else if (r == 11) for (int i = 0; i < NUM_CH; i++) v[i] = m_to[i];
      return v;
   endfunction

   // advance the reference by one clk with the given bus access
   task automatic mstep(input bit we, input logic [AW-1:0] a, input logic [15:0] d);
      int tc, r;
      tc = int'(a) / 16; r = int'(a) % 16;
      for (int c = 0; c < NUM_CH; c++) begin
         bit w, evt, tick, clr, run0;
         longint unsigned old;
         int sh;
         w = we && (c == tc);
         old = m_cnt[c];
         run0 = m_run[c];
         evt = (old == 0) && m_wasnz[c];
         m_wasnz[c] = (old != 0);
         tick = PSC ? (m_pc[c] >= m_psc[c]) : 1'b1;
         clr = 0;
         if (w && r >= 6 && r < 6 + NHW) m_snap[c] = old;
         if (run0 && tick) begin
            if (old == 0) begin
               m_cnt[c] = m_per[c]; clr = 1;
               if (!m_ctl[c][1]) m_run[c] = 0;
            end else m_cnt[c] = old - 1;
         end
         if (run0) m_pc[c] = tick ? 0 : m_pc[c] + 1;
         if (w && r == 1) begin
            m_ctl[c] = d[3:0];
            if (d[2]) begin m_run[c] = 1; clr = 1; end
            else if (d[3]) m_run[c] = 0;
         end
         if (w && r >= 2 && r < 2 + NHW) begin
            sh = 16 * (r - 2);
            m_per[c] = (m_per[c] & ~(64'hFFFF << sh)) | (64'(d) << sh);
            m_cnt[c] = m_per[c]; m_run[c] = 0; clr = 1;
         end
         if (w && r == 10) m_psc[c] = int'(d);
         if (clr) m_pc[c] = 0;
         if (w && r == 0) m_to[c] = 0;
         else if (evt) m_to[c] = 1;
      end
   endtask

   task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, ncyc);
      end
   endtask

   // one clk of bus activity, checked against the reference
   task automatic cyc(input bit we, input logic [AW-1:0] a, input logic [15:0] d);
      logic [15:0] e;
      address    = a;
      chipselect = we ? 1'b1 : 1'($urandom_range(0, 1));
      write_n    = we ? 1'b0 : (chipselect ? 1'b1 : 1'($urandom_range(0, 1)));
      writedata  = we ? d : 16'($urandom);
      e = mread(a);
      @(posedge clk); #1;
      mstep(we, a, d);
      ncyc++;
      chk("model_rdata", readdata, e);
      chk("model_irq", 16'(irq), 16'(m_irq()));
   endtask

   task automatic wait_irq(input int lim, output int t);
      t = -1;
      for (int i = 0; i < lim && t < 0; i++) begin
         if (irq) t = ncyc;
         else cyc(0, ad(0, 0), 16'h0);
      end
      if (t < 0 && irq) t = ncyc;
      if (t < 0) begin
         checks++; failures++;
         $display("FAIL irq_wait: no irq within %0d cycles", lim);
         t = ncyc;
      end
   endtask

   initial begin
      vec_t tbl[15];
      int t1, t2;
      reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
      address = '0; writedata = 16'h0;
      m_reset();
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      chk("rst_rdata", readdata, 16'h0);
      chk("rst_irq", 16'(irq), 16'h0);

      tbl[0]  = '{0, ad(0, 2),  16'h0,    16'hC34F};
      tbl[1]  = '{0, ad(0, 3),  16'h0,    16'h0000};
      tbl[2]  = '{0, ad(0, 0),  16'h0,    16'h0000};
      tbl[3]  = '{0, ad(3, 2),  16'h0,    16'hC34F};
      tbl[4]  = '{1, ad(1, 6),  16'h0,    16'h0000};
      tbl[5]  = '{0, ad(1, 6),  16'h0,    16'hC34F};
      tbl[6]  = '{1, ad(2, 4),  16'hABCD, 16'h0000};
      tbl[7]  = '{0, ad(2, 4),  16'h0,    16'h0000};
      tbl[8]  = '{1, ad(2, 12), 16'h1234, 16'h0000};
      tbl[9]  = '{0, ad(2, 12), 16'h0,    16'h0000};
      tbl[10] = '{0, ad(0, 11), 16'h0,    16'h0000};
      tbl[11] = '{1, ad(1, 1),  16'h0002, 16'h0000};
      tbl[12] = '{0, ad(1, 1),  16'h0,    16'h0002};
      tbl[13] = '{0, ad(0, 1),  16'h0,    16'h0000};
      tbl[14] = '{0, ad(0, 10), 16'h0,    16'h0000};
      for (int i = 0; i < 15; i++) begin
         cyc(tbl[i].we, tbl[i].a, tbl[i].d);
         chk($sformatf("tbl%0d", i), readdata, tbl[i].exp);
      end

      // ch1 continuous, period 9
      cyc(1, ad(1, 2), 16'd9);
      cyc(1, ad(1, 3), 16'd0);
      cyc(1, ad(1, 1), 16'h7);
      wait_irq(40, t1);
      cyc(0, ad(1, 11), 16'h0);
      chk("ch1_pending", readdata, 16'h0002);
      cyc(1, ad(1, 0), 16'h0);
      chk("ch1_irq_clear", 16'(irq), 16'h0);
      wait_irq(40, t2);
      chk("ch1_interval", 16'(t2 - t1), 16'd10);
      cyc(1, ad(1, 1), 16'h8);
      cyc(1, ad(1, 0), 16'h0);

      // ch2 one-shot, period 3
      cyc(1, ad(2, 2), 16'd3);
      cyc(1, ad(2, 1), 16'h5);
      wait_irq(40, t1);
      repeat (20) cyc(0, ad(2, 0), 16'h0);
      chk("ch2_oneshot_status", readdata, 16'h0001);
      cyc(1, ad(2, 0), 16'h0);
      repeat (30) cyc(0, ad(2, 0), 16'h0);
      chk("ch2_single_to", 16'(irq), 16'h0);
      chk("ch2_stopped", readdata, 16'h0000);
      cyc(1, ad(2, 6), 16'h0);
      cyc(0, ad(2, 6), 16'h0);
      chk("ch2_reloaded", readdata, 16'd3);

      // ch0 START+STOP, then period write while running
      cyc(1, ad(0, 1), 16'hC);
      cyc(0, ad(0, 0), 16'h0);
      chk("ch0_start_wins", readdata, 16'h0002);
      cyc(0, ad(0, 1), 16'h0);
      chk("ch0_ctrl_rb", readdata, 16'h000C);
      cyc(1, ad(0, 2), 16'h0100);
      cyc(1, ad(0, 6), 16'h0);
      cyc(0, ad(0, 0), 16'h0);
      chk("ch0_force_reload", readdata, 16'h0000);
      cyc(0, ad(0, 6), 16'h0);
      chk("ch0_snap", readdata, 16'h0100);

      // ch3 prescale 4, period 2
      cyc(1, ad(3, 2), 16'd2);
      cyc(1, ad(3, 10), 16'd4);
      cyc(0, ad(3, 10), 16'h0);
      chk("ch3_prescale_rb", readdata, PSC ? 16'd4 : 16'd0);
      cyc(1, ad(3, 1), 16'h7);
      wait_irq(100, t1);
      cyc(1, ad(3, 0), 16'h0);
      wait_irq(100, t2);
      chk("ch3_interval", 16'(t2 - t1), 16'(EXP_I));

      // status write on the same clk as the timeout event
      cyc(1, ad(3, 0), 16'h0);
      repeat (EXP_I - 2) cyc(0, ad(3, 0), 16'h0);
      cyc(1, ad(3, 0), 16'h0);
      chk("collide_irq", 16'(irq), 16'h0);
      cyc(0, ad(3, 0), 16'h0);
      chk("collide_status", readdata, 16'h0002);

      // asynchronous reset mid-count
      wait_irq(100, t1);
      reset_n = 1'b0;
      #2;
      chk("async_rst_irq", 16'(irq), 16'h0);
      chk("async_rst_rdata", readdata, 16'h0);
      @(posedge clk); @(posedge clk); #1;
      reset_n = 1'b1;
      m_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         cyc(0, ad(c, 2), 16'h0);
         chk($sformatf("rst_per_ch%0d", c), readdata, 16'hC34F);
         cyc(0, ad(c, 0), 16'h0);
         chk($sformatf("rst_st_ch%0d", c), readdata, 16'h0);
         cyc(0, ad(c, 1), 16'h0);
         chk($sformatf("rst_ctl_ch%0d", c), readdata, 16'h0);
      end

      // randomized traffic against the reference
      for (int i = 0; i < 2500; i++) begin
         int c, r;
         bit we;
         logic [15:0] d;
         c  = $urandom_range(0, NUM_CH - 1);
         r  = $urandom_range(0, 15);
         we = ($urandom_range(0, 3) == 0);
         case (r)
            2:       d = 16'($urandom_range(0, 20));
            3, 4, 5: d = 16'($urandom_range(0, 7) == 0);
            10:      d = 16'($urandom_range(0, 3));
            1:       d = 16'($urandom_range(0, 15));
            default: d = 16'($urandom);
         endcase
         cyc(we, ad(c, r), d);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/avalon_multi_timer.md
# avalon_multi_timer

Parametrised multi-channel interval timer with an Avalon-MM 16-bit slave, the successor to the single-channel interval timer in the Platform Designer system. It provides NUM_CH independent down-counters of CNT_W bits, each with one-shot or continuous mode, a snapshot and an optional clock prescaler. All channel interrupts are merged onto one level-sensitive irq, and a pending bitmap tells software which channel fired.

## Interface
- NUM_CH, 4: channel count, 1..8.
- CNT_W, 32: counter and period width, one of 16, 32, 48 or 64.
- RESET_PERIOD, 49999: reset value of every period register and counter.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  4+$clog2(NUM_CH)  bus address, where {ch, reg[3:0]} selects channel ch and register reg.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write.
- writedata  in  16  write data.
- readdata  out  16  registered read data.
- irq  out  1  OR over channels of (TO & ITO).

## Operation
- Per-channel registers (reg offset):
  - 0 status: RUN at bit1 and TO at bit0. Any write clears TO.
  - 1 control: STOP at bit3, START at bit2, CONT at bit1, ITO at bit0. Bits 1:0 are stored. Bits 3:2 are strobes that read back as written.
  - 2..5 period halfwords 0..3.
  - 6..9 snapshot halfwords 0..3.
  - 10 prescale, 16 bits.
  - 11 pending: global read-only bitmap of the TO bits, identical in every channel window.
  - 12..15 are reserved: they read 0 and writes are ignored.
- Halfwords at index CNT_W/16 and above read 0, and writes to them are ignored. A channel index of NUM_CH or above reads 0, and writes to it are ignored.
- Period write: on the next clk the counter loads the full period value and RUN clears (force reload).
- START strobe: RUN sets. STOP strobe: RUN clears. If START and STOP are written together, START wins.
- Counting:
  - While RUN is set and a tick occurs, the counter decrements.
  - At 0 it reloads the period instead of decrementing.
  - If CONT=0 the channel stops when the counter is 0.
- Timeout event: the counter is 0 and was not 0 on the previous clk. The event sets TO. A status write on the same cycle as an event wins, leaving TO=0.
- Snapshot: a write to any snapshot halfword captures the whole counter value from before that cycle's update.
- Period 0 in continuous mode: TO fires once, then the counter stays at 0 until a new period is written.
- Prescaler:
  - With prescale value P, a tick occurs every P+1 clks.
  - The prescale counter clears on START and on any reload.
- Reset values:
  - readdata=0, irq=0, RUN=0, TO=0, control=0, snapshot=0.
  - period=counter=RESET_PERIOD, prescale=0.
- Asserting reset mid-count returns every channel to these reset values immediately.

## Timing
- Reads have 1-cycle latency. readdata updates every clk from the address, regardless of chipselect.
- Writes take effect on the clk edge where chipselect=1 and write_n=0. There are no wait states.
- irq is combinational from registered TO and ITO. It rises 1 clk after the counter reaches 0, i.e. on the clk after the timeout event.
- With RUN set and P=0, a period of N gives a timeout every N+1 clks.
- A write to one channel never affects another channel's state.

## Configuration
- TIMER_PRESCALER_EN defined: per-channel prescale registers and prescale counters exist.
- TIMER_PRESCALER_EN undefined: every clk is a tick, no prescale flops are built, and reg 10 reads 0 with writes ignored.

## Structure
- Shared package timer_pkg holds:
  - register offset constants (REG_STATUS..REG_PENDING);
  - control and status bit positions;
  - the halfword width localparam (16).
- Sub-module timer_channel holds one channel's counter, period, snapshot, prescaler and TO/RUN logic. The top level instantiates NUM_CH copies in a generate loop, decodes the address, muxes readdata and ORs irq.

## Test plan
- Reset, then read ch0 reg 2 -> 0xC34F. Read reg 0 -> 0x0000. irq=0.
- Ch1: write period 9, then control 0x7 (START, CONT, ITO) -> TO sets every 10 clks. Write status -> irq drops next cycle. Pending reads 0x0002.
- Ch2 one-shot: write period 3, then control 0x5 -> exactly one TO. RUN reads 0 after it, and the counter holds 3 after reloading.
- Ch0: write START and STOP together (control 0xC) -> RUN=1. Write period while running -> RUN=0, and a snapshot next clk reads the new period.
- Ch3 with prescale 4 and period 2 (TIMER_PRESCALER_EN defined) -> timeout every 15 clks. Without the macro -> every 3 clks, and reg 10 reads 0.
- TO event and status write on the same clk -> TO=0 and irq stays low. Reset asserted mid-count -> all channels return to reset values.
